exception_csr: RTL

EXCEPTION_CSR -- requirements
Module: exception_csr

---
 rtl/exception_csr.sv | 174 +++++++++++++++++
 1 files changed

// File: rtl/exception_csr.sv
// ---------------------------------------------------------------------------
// exception_csr
//
// Exception/interrupt control and status registers for a small core.
// Holds STATUS (EXL/IE/TE), SCAUSE (pending event bits), INTMASK and TIMECMP,
// plus the saved trap PC (sepc), the cause being handled (hcause) and an
// 8-bit timer that raises a one-cycle interrupt pulse (Int).
//
// Ports
//   clk       in   rising-edge clock
//   rst       in   asynchronous active-low reset
//   csr_we    in   CSR write strobe
//   csr_addr  in   [1:0] 00 STATUS, 01 SCAUSE, 10 INTMASK, 11 TIMECMP
//   csr_wdata in   [7:0] CSR write data
//   csr_rdata out  [7:0] combinational read of the selected CSR
//   exc_src   in   [7:0] exception event pulses, bit k sets SCAUSE[k]
//   EXL_Set   in   trap-taken strobe
//   INT_PEND  in   [2:0] cause code of the trap being taken
//   int_ret   in   return-from-handler strobe
//   pc        in   [31:0] PC of the trapping instruction
//   STATUS    out  [7:0] {5'b0, TE, IE, EXL}
//   SCAUSE    out  [7:0] pending cause bits
//   INTMASK   out  [7:0] interrupt mask register
//   Int       out  registered one-cycle timer interrupt pulse
//   sepc      out  [31:0] saved trap PC
//   hcause    out  [2:0] cause code of the trap being handled
// ---------------------------------------------------------------------------
module exception_csr (
  input  logic        clk,
  input  logic        rst,
  input  logic        csr_we,
  input  logic [1:0]  csr_addr,
  input  logic [7:0]  csr_wdata,
  output logic [7:0]  csr_rdata,
  input  logic [7:0]  exc_src,
  input  logic        EXL_Set,
  input  logic [2:0]  INT_PEND,
  input  logic        int_ret,
  input  logic [31:0] pc,
  output logic [7:0]  STATUS,
  output logic [7:0]  SCAUSE,
  output logic [7:0]  INTMASK,
  output logic        Int,
  output logic [31:0] sepc,
  output logic [2:0]  hcause
);

  localparam logic [1:0] AddrStatus  = 2'b00;
  localparam logic [1:0] AddrScause  = 2'b01;
  localparam logic [1:0] AddrIntmask = 2'b10;
  localparam logic [1:0] AddrTimecmp = 2'b11;

  // Only three STATUS bits are storage; the upper five are constant zero.
  logic        exl_q, exl_d;
  logic        ie_q, ie_d;
  logic        te_q, te_d;
  logic [7:0]  scause_q, scause_d;
  logic [7:0]  intmask_q, intmask_d;
  logic [7:0]  timecmp_q, timecmp_d;
  logic [7:0]  count_q, count_d;
  logic        int_q, int_d;
  logic [31:0] sepc_q, sepc_d;
  logic [2:0]  hcause_q, hcause_d;

  logic       trapLoad;
  logic       retTaken;
  logic       timerMatch;
  logic [7:0] scauseBase;
  logic [7:0] clearMask;

  // A trap is taken when not already in a handler. A trap arriving together
  // with a return is treated as back-to-back handling: the return is
  // swallowed and the trap reloads sepc/hcause with EXL staying set.
  assign trapLoad   = EXL_Set && (!exl_q || int_ret);
  assign retTaken   = int_ret && exl_q && !EXL_Set;
  assign timerMatch = te_q && (count_q == timecmp_q);

  // Next-state logic for every register. Compare uses the current TIMECMP,
  // so a write landing on a match cycle only affects later compares.
  always_comb begin
    exl_d     = exl_q;
    ie_d      = ie_q;
    te_d      = te_q;
    intmask_d = intmask_q;
    timecmp_d = timecmp_q;
    sepc_d    = sepc_q;
    hcause_d  = hcause_q;
    count_d   = count_q;
    int_d     = 1'b0;
    clearMask = 8'h00;

    if (trapLoad) begin
      exl_d    = 1'b1;
      sepc_d   = pc;
      hcause_d = INT_PEND;
    end else if (retTaken) begin
      exl_d = 1'b0;
      // Cause 7 is the timer, which has no SCAUSE bit to acknowledge.
      if (hcause_q != 3'd7) begin
        clearMask = 8'h01 << hcause_q;
      end
    end

    if (csr_we) begin
      case (csr_addr)
        AddrStatus: begin
          ie_d = csr_wdata[1];
          te_d = csr_wdata[2];
        end
        AddrIntmask: intmask_d = csr_wdata;
        AddrTimecmp: timecmp_d = csr_wdata;
        default: ;
      endcase
    end

    // New events are ORed in last so they win over a same-cycle clear.
    scauseBase = (csr_we && (csr_addr == AddrScause)) ? csr_wdata : scause_q;
    scause_d   = (scauseBase & ~clearMask) | exc_src;

    if (te_q) begin
      count_d = timerMatch ? 8'h00 : count_q + 8'h01;
    end

    // A match outside the enabled, non-handler window is simply dropped.
    int_d = timerMatch && ie_q && !exl_q;
  end

  // State registers; reset forces everything to its idle value at once.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      exl_q     <= 1'b0;
      ie_q      <= 1'b0;
      te_q      <= 1'b0;
      scause_q  <= 8'h00;
      intmask_q <= 8'h03;
      timecmp_q <= 8'hFF;
      count_q   <= 8'h00;
      int_q     <= 1'b0;
      sepc_q    <= 32'h0000_0000;
      hcause_q  <= 3'd0;
    end else begin
      exl_q     <= exl_d;
      ie_q      <= ie_d;
      te_q      <= te_d;
      scause_q  <= scause_d;
      intmask_q <= intmask_d;
      timecmp_q <= timecmp_d;
      count_q   <= count_d;
      int_q     <= int_d;
      sepc_q    <= sepc_d;
      hcause_q  <= hcause_d;
    end
  end

  assign STATUS  = {5'b00000, te_q, ie_q, exl_q};
  assign SCAUSE  = scause_q;
  assign INTMASK = intmask_q;
  assign Int     = int_q;
  assign sepc    = sepc_q;
  assign hcause  = hcause_q;

  // Reads show the stored values only; a same-cycle write is not bypassed.
  always_comb begin
    csr_rdata = 8'h00;
    case (csr_addr)
      AddrStatus:  csr_rdata = STATUS;
      AddrScause:  csr_rdata = scause_q;
      AddrIntmask: csr_rdata = intmask_q;
      AddrTimecmp: csr_rdata = timecmp_q;
      default:     csr_rdata = 8'h00;
    endcase
  end

endmodule
